// File: rtl/ser_pkg.sv
// Shared types and default sizing for the bit serializer.
package ser_pkg;

    // Serializer FSM encoding
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word input and serial bit output bundle of the serializer.
interface bit_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              ser_en;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_last;
    logic              busy;

    // Upstream/downstream side that drives words and consumes bits
    modport master (
        output din, din_valid, ser_en,
        input  din_ready, ser_out, ser_valid, ser_last, busy
    );

    // Serializer side
    modport slave (
        input  din, din_valid, ser_en,
        output din_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/ser_fifo.sv
// Small word FIFO with a head-of-queue read port; pointers wrap naturally
// because the depth is a power of two.
module ser_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointer and occupancy tracking; push+pop together leaves count alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/bit_serializer.sv
// Buffers parallel words in a FIFO and shifts them out one bit per ser_en
// edge, chaining words back-to-back with no idle gap.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bit_serializer_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  bit_idx;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic              push_w, pop_w;
    logic              shifting, at_last;

    ser_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_w),
        .data_i  (bus.din),
        .pop_i   (pop_w),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Ready comes only from the registered count, so a same-cycle pop
    // never opens the door for a push into a full FIFO.
    assign bus.din_ready = (fifo_count < FCW'(FIFO_DEPTH));
    assign push_w        = bus.din_valid && !fifo_full;

    assign shifting = (state_q == SHIFT);
    assign at_last  = (cnt_q == CNT_W'(DATA_W - 1));
    assign bit_idx  = MSB_FIRST ? (CNT_W'(DATA_W - 1) - cnt_q) : cnt_q;

    assign bus.ser_valid = shifting;
    assign bus.ser_last  = shifting && at_last;
    assign bus.ser_out   = shifting && shreg_q[bit_idx];
    assign bus.busy      = shifting || !fifo_empty;

    // FSM, shifter and bit counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: load from FIFO head when idle or at the consumed last bit
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        pop_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_w   = 1'b1;
                    shreg_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_en) begin
                    if (at_last) begin
                        cnt_d = '0;
                        if (!fifo_empty) begin
                            pop_w   = 1'b1;
                            shreg_d = fifo_dout;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
